riscv_stage_ctrl: RTL

RISCV_STAGE_CTRL -- requirements
Module: riscv_stage_ctrl

---
 rtl/riscv_stage_ctrl.sv | 61 ++++++
 1 files changed

// File: rtl/riscv_stage_ctrl.sv
// riscv_stage_ctrl: five-stage pipeline sequencing FSM with stall/flush valid tracking and retire counter
module riscv_stage_ctrl #(
  parameter int RET_W = 32
) (
  input  logic             i_clk_IF,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_halt_req,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [4:0]       o_stage_en,
  output logic [4:0]       o_stage_vld,
  output logic             o_fetch_req,
  output logic [1:0]       o_state,
  output logic             o_busy,
  output logic             o_halted,
  output logic [RET_W-1:0] o_retired
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, HALT = 2'b11} state_t;
  state_t           state_q, state_d;
  logic [4:0]       vld_q, vld_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic             s, active;
  // next state, stage enables, valid shift and retire count
  always_comb begin
    s = i_stall & ~i_flush;
    active = (state_q == RUN) || (state_q == DRAIN);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_start ? RUN : (i_halt_req ? HALT : IDLE);
      RUN:     state_d = i_halt_req ? DRAIN : RUN;
      DRAIN:   state_d = (vld_q == 5'b00000) ? HALT : DRAIN;
      default: state_d = i_start ? RUN : HALT;
    endcase
    o_stage_en = active ? (s ? 5'b11100 : 5'b11111) : 5'b00000;
    o_fetch_req = (state_q == RUN) && !s;
    vld_d = vld_q;
    if (active) begin
      vld_d = s ? {vld_q[3], vld_q[2], 1'b0, vld_q[1:0]} : {vld_q[3:0], o_fetch_req};
      if (i_flush) vld_d[2:1] = 2'b00;
    end
    ret_d = ret_q + RET_W'(active && vld_q[4]);
  end
  // state, valid and retire registers with synchronous active-low reset
  always_ff @(posedge i_clk_IF) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      vld_q <= '0;
      ret_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q <= vld_d;
      ret_q <= ret_d;
    end
  end
  assign o_stage_vld = vld_q;
  assign o_state = state_q;
  assign o_busy = (state_q == RUN) || (state_q == DRAIN);
  assign o_halted = state_q == HALT;
  assign o_retired = ret_q;
endmodule
